// File: rtl/rif_arb_pkg.sv
// rif_arb_pkg: shared definitions for the RIF port arbiter.
//   NUM_REQ     - number of requesters sharing the RIF port
//   arb_state_t - arbiter FSM state encoding
package rif_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant logic.
// Ports:
//   aclk, aresetn - clock, async active-low reset
//   req           - request vector, one bit per requester
//   upd_en        - record upd_idx as the most recent grant
//   upd_idx       - index of the requester just served
//   grant         - one-hot combinational grant (0 when no request)
//   grant_idx     - index form of grant
module rr_arbiter2
    import rif_arb_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd_en,
    input  logic               upd_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    logic last_grant;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= 1'b1;
        end else if (upd_en) begin
            last_grant <= upd_idx;
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_idx = ~last_grant;
                grant     = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant     = '0;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rif_port_arbiter.sv
// rif_port_arbiter: shares one single-port RIF between two requesters.
// One transaction at a time: IDLE (accept) -> ISSUE (one RIF cycle) -> RESP
// (hold response until the granted requester consumes it).
// Ports:
//   aclk, aresetn                        - clock, async active-low reset
//   req_valid/write/addr/wdata/wstrb     - per-requester request inputs
//   req_ready                            - one-hot accept, IDLE only
//   rsp_valid, rsp_ready                 - per-requester response handshake
//   rsp_rdata, rsp_err                   - shared response payload
//   rif_addr/wr_req/rd_req/wstrb/wdata   - RIF request side
//   rif_wvalid/rvalid/rdata              - RIF hit flags and read data
// Optional feature: define RIF_ARB_STATS_EN to add saturating 16-bit
// per-requester accept counters grant_cnt0 / grant_cnt1.
module rif_port_arbiter
    import rif_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0]                      req_write,
    input  logic [NUM_REQ-1:0][AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][AXI_DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][AXI_BYTE_COUNT-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                    rsp_err,
    input  logic [NUM_REQ-1:0]                      rsp_ready,
    output logic [AXI_ADDR_WIDTH-1:0]               rif_addr,
    output logic                                    rif_wr_req,
    output logic                                    rif_rd_req,
    output logic [AXI_BYTE_COUNT-1:0]               rif_wstrb,
    output logic [AXI_DATA_WIDTH-1:0]               rif_wdata,
    input  logic                                    rif_wvalid,
    input  logic                                    rif_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]               rif_rdata
`ifdef RIF_ARB_STATS_EN
    ,
    output logic [15:0]                             grant_cnt0,
    output logic [15:0]                             grant_cnt1
`endif
);

    arb_state_t         state;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_idx;
    logic               gnt_idx;
    logic               wr_flag;
    logic               accept;

    rr_arbiter2 u_rr (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req_valid),
        .upd_en    (state == ISSUE),
        .upd_idx   (gnt_idx),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            req_ready = arb_grant;
        end
    end

    assign accept = (state == IDLE) && (|req_valid);

    // rif_addr/wdata/wstrb double as the request latches, so they naturally
    // hold the last accepted values outside ISSUE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            gnt_idx    <= 1'b0;
            wr_flag    <= 1'b0;
            rif_addr   <= '0;
            rif_wdata  <= '0;
            rif_wstrb  <= '0;
            rif_wr_req <= 1'b0;
            rif_rd_req <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rif_addr   <= req_addr[arb_idx];
                        rif_wdata  <= req_wdata[arb_idx];
                        rif_wstrb  <= req_wstrb[arb_idx];
                        wr_flag    <= req_write[arb_idx];
                        gnt_idx    <= arb_idx;
                        rif_wr_req <= req_write[arb_idx];
                        rif_rd_req <= ~req_write[arb_idx];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rif_wr_req <= 1'b0;
                    rif_rd_req <= 1'b0;
                    rsp_rdata  <= wr_flag ? '0 : rif_rdata;
                    rsp_err    <= wr_flag ? ~rif_wvalid : ~rif_rvalid;
                    rsp_valid  <= gnt_idx ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RIF_ARB_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (!arb_idx && grant_cnt0 != '1) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (arb_idx && grant_cnt1 != '1) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rif_port_arbiter.sv
// tb_rif_port_arbiter: directed, table-driven bench for rif_port_arbiter.
module tb_rif_port_arbiter;

    logic             aclk;
    logic             aresetn;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][11:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_wstrb;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [1:0]       rsp_ready;
    logic [11:0]      rif_addr;
    logic             rif_wr_req;
    logic             rif_rd_req;
    logic [3:0]       rif_wstrb;
    logic [31:0]      rif_wdata;
    logic             rif_wvalid;
    logic             rif_rvalid;
    logic [31:0]      rif_rdata;
`ifdef RIF_ARB_STATS_EN
    logic [15:0]      grant_cnt0;
    logic [15:0]      grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    rif_port_arbiter #(
        .AXI_ADDR_WIDTH (12),
        .AXI_DATA_WIDTH (32),
        .AXI_BYTE_COUNT (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .rif_addr   (rif_addr),
        .rif_wr_req (rif_wr_req),
        .rif_rd_req (rif_rd_req),
        .rif_wstrb  (rif_wstrb),
        .rif_wdata  (rif_wdata),
        .rif_wvalid (rif_wvalid),
        .rif_rvalid (rif_rvalid),
        .rif_rdata  (rif_rdata)
`ifdef RIF_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]       valid;
        logic [1:0]       write;
        logic [1:0][11:0] addr;
        logic [1:0][31:0] wdata;
        logic [1:0][3:0]  wstrb;
        logic             wvalid;
        logic             rvalid;
        logic [31:0]      rdata;
        logic [1:0]       e_grant;
        logic             e_wr;
        logic             e_rd;
        logic [11:0]      e_addr;
        logic [31:0]      e_wdata;
        logic [3:0]       e_wstrb;
        logic [31:0]      e_rdata;
        logic             e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [1:0] valid, input logic [1:0] write,
        input logic [11:0] a0, input logic [11:0] a1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [3:0] s0, input logic [3:0] s1,
        input logic wv, input logic rv, input logic [31:0] rd,
        input logic [1:0] eg, input logic ewr, input logic erd,
        input logic [11:0] ea, input logic [31:0] ed, input logic [3:0] es,
        input logic [31:0] erdata, input logic eerr);
        vec_t v;
        v.valid = valid;  v.write = write;
        v.addr[0] = a0;   v.addr[1] = a1;
        v.wdata[0] = d0;  v.wdata[1] = d1;
        v.wstrb[0] = s0;  v.wstrb[1] = s1;
        v.wvalid = wv;    v.rvalid = rv;   v.rdata = rd;
        v.e_grant = eg;   v.e_wr = ewr;    v.e_rd = erd;
        v.e_addr = ea;    v.e_wdata = ed;  v.e_wstrb = es;
        v.e_rdata = erdata; v.e_err = eerr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge aclk);
        req_valid  = v.valid;
        req_write  = v.write;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_wstrb  = v.wstrb;
        rif_wvalid = v.wvalid;
        rif_rvalid = v.rvalid;
        rif_rdata  = v.rdata;
        rsp_ready  = 2'b00;
        #1;
        chk("idle_req_ready", req_ready, v.e_grant);
        chk("idle_no_rif_req", {rif_wr_req, rif_rd_req}, 2'b00);
        @(negedge aclk);
        chk("issue_req_ready", req_ready, 2'b00);
        chk("issue_wr_req", rif_wr_req, v.e_wr);
        chk("issue_rd_req", rif_rd_req, v.e_rd);
        chk("issue_addr", rif_addr, v.e_addr);
        chk("issue_wdata", rif_wdata, v.e_wdata);
        chk("issue_wstrb", rif_wstrb, v.e_wstrb);
        req_valid = 2'b00;
        @(negedge aclk);
        chk("resp_valid", rsp_valid, v.e_grant);
        chk("resp_rdata", rsp_rdata, v.e_rdata);
        chk("resp_err", rsp_err, v.e_err);
        chk("resp_no_rif_req", {rif_wr_req, rif_rd_req}, 2'b00);
        chk("resp_addr_hold", rif_addr, v.e_addr);
        rsp_ready = 2'b11;
        @(negedge aclk);
        chk("resp_done", rsp_valid, 2'b00);
        rsp_ready = 2'b00;
    endtask

    logic [6:0] lat_ready;
    logic [6:0] lat_rd;
    logic [6:0] lat_rsp;

    initial begin
        aresetn    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        rsp_ready  = '0;
        rif_wvalid = 1'b0;
        rif_rvalid = 1'b0;
        rif_rdata  = '0;

        //            valid  write a0      a1      d0            d1            s0    s1    wv    rv    rdata
        //            grant  wr    rd      addr    wdata         wstrb rdata         err
        vecs[0] = mkv(2'b01, 2'b00, 12'h010, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D,
                      2'b01, 1'b0, 1'b1, 12'h010, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        vecs[1] = mkv(2'b10, 2'b10, 12'h000, 12'h0FC, 32'h0, 32'h12345678, 4'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF,
                      2'b10, 1'b1, 1'b0, 12'h0FC, 32'h12345678, 4'hF, 32'h0, 1'b1);
        vecs[2] = mkv(2'b11, 2'b10, 12'h020, 12'h030, 32'h01010101, 32'hAAAA5555, 4'h0, 4'h3, 1'b1, 1'b0, 32'h11112222,
                      2'b01, 1'b0, 1'b1, 12'h020, 32'h01010101, 4'h0, 32'h11112222, 1'b1);
        vecs[3] = mkv(2'b11, 2'b10, 12'h020, 12'h030, 32'h01010101, 32'hAAAA5555, 4'h0, 4'h3, 1'b1, 1'b0, 32'h11112222,
                      2'b10, 1'b1, 1'b0, 12'h030, 32'hAAAA5555, 4'h3, 32'h0, 1'b0);
        vecs[4] = mkv(2'b11, 2'b00, 12'h040, 12'h050, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h0BADCAFE,
                      2'b01, 1'b0, 1'b1, 12'h040, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0);
        vecs[5] = mkv(2'b11, 2'b00, 12'h040, 12'h050, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'h55667788,
                      2'b10, 1'b0, 1'b1, 12'h050, 32'h0, 4'h0, 32'h55667788, 1'b0);
        vecs[6] = mkv(2'b10, 2'b00, 12'h000, 12'hFFF, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 32'hFFFFFFFF,
                      2'b10, 1'b0, 1'b1, 12'hFFF, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0);
        vecs[7] = mkv(2'b01, 2'b01, 12'h000, 12'h000, 32'h87654321, 32'h0, 4'h1, 4'h0, 1'b1, 1'b0, 32'h13579BDF,
                      2'b01, 1'b1, 1'b0, 12'h000, 32'h87654321, 4'h1, 32'h0, 1'b0);

        // Reset state
        #1;
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rif_req", {rif_wr_req, rif_rd_req}, 2'b00);
        chk("rst_rif_addr", rif_addr, 12'h000);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Latency: accept N, RIF request N+1, response N+2, next accept N+3
        lat_ready = 7'b1001001;
        lat_rd    = 7'b0100100;
        lat_rsp   = 7'b0010010;
        @(negedge aclk);
        req_valid  = 2'b01;
        req_write  = 2'b00;
        req_addr   = '0;
        req_addr[0] = 12'h100;
        rif_rvalid = 1'b1;
        rif_rdata  = 32'h24681357;
        rsp_ready  = 2'b11;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("lat_req_ready", req_ready[0], lat_ready[6-k]);
            chk("lat_rd_req", rif_rd_req, lat_rd[6-k]);
            chk("lat_rsp_valid", rsp_valid[0], lat_rsp[6-k]);
            if (k == 6) begin
                req_valid = 2'b00;
                rsp_ready = 2'b00;
            end
            @(negedge aclk);
        end

        // Backpressure: response held while granted rsp_ready stays low
        req_valid  = 2'b01;
        req_addr[0] = 12'h200;
        rif_rdata  = 32'hA5A5A5A5;
        rif_rvalid = 1'b1;
        rsp_ready  = 2'b00;
        @(negedge aclk);
        @(negedge aclk);
        rif_rdata = 32'h0;
        rif_rvalid = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
            chk("bp_rsp_err", rsp_err, 1'b0);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_no_rif_req", {rif_wr_req, rif_rd_req}, 2'b00);
            @(negedge aclk);
        end
        rsp_ready = 2'b01;
        @(negedge aclk);
        #1;
        chk("bp_released", rsp_valid, 2'b00);
        chk("bp_next_grant", req_ready, 2'b10);
        req_valid = 2'b00;
        rsp_ready = 2'b00;

`ifdef RIF_ARB_STATS_EN
        chk("stats_cnt0", grant_cnt0, 16'd7);
        chk("stats_cnt1", grant_cnt1, 16'd4);
`endif

        // Reset during ISSUE aborts the transaction
        @(negedge aclk);
        req_valid  = 2'b01;
        req_write  = 2'b00;
        req_addr[0] = 12'h3AB;
        rif_rdata  = 32'h77777777;
        rif_rvalid = 1'b1;
        @(posedge aclk);
        #1;
        chk("rstmid_issue_rd", rif_rd_req, 1'b1);
        aresetn   = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rstmid_rd_req", rif_rd_req, 1'b0);
        chk("rstmid_wr_req", rif_wr_req, 1'b0);
        chk("rstmid_addr", rif_addr, 12'h000);
        chk("rstmid_wdata", rif_wdata, 32'h0);
        chk("rstmid_wstrb", rif_wstrb, 4'h0);
        chk("rstmid_rsp_valid", rsp_valid, 2'b00);
        chk("rstmid_rsp_rdata", rsp_rdata, 32'h0);
        chk("rstmid_rsp_err", rsp_err, 1'b0);
        chk("rstmid_req_ready", req_ready, 2'b00);
`ifdef RIF_ARB_STATS_EN
        chk("rstmid_cnt0", grant_cnt0, 16'd0);
        chk("rstmid_cnt1", grant_cnt1, 16'd0);
`endif
        @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("post_rst_rsp_valid", rsp_valid, 2'b00);
            chk("post_rst_rif_req", {rif_wr_req, rif_rd_req}, 2'b00);
        end
        req_valid = 2'b11;
        #1;
        chk("post_rst_tie_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rif_port_arbiter.md
RIF_PORT_ARBITER -- requirements
Module: rif_port_arbiter

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 12, RIF address width.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, RIF data width.
REQ-003 Parameter AXI_BYTE_COUNT, default AXI_DATA_WIDTH/8, write strobe width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low. aclk  in  1  clock; aresetn  in  1  async active-low reset.
REQ-005 Requester ports, packed [1:0], index = requester:
- req_valid  in  2  request pending
- req_write  in  2  1=write, 0=read
- req_addr  in  2xAXI_ADDR_WIDTH  address
- req_wdata  in  2xAXI_DATA_WIDTH  write data
- req_wstrb  in  2xAXI_BYTE_COUNT  write strobes
- req_ready  out  2  request accepted this cycle
- rsp_valid  out  2  response available
- rsp_rdata  out  AXI_DATA_WIDTH  read data, shared by both requesters
- rsp_err  out  1  1=SLVERR, shared
- rsp_ready  in  2  response consumed
REQ-006 Single-port RIF side:
- rif_addr  out  AXI_ADDR_WIDTH
- rif_wr_req  out  1
- rif_rd_req  out  1
- rif_wstrb  out  AXI_BYTE_COUNT
- rif_wdata  out  AXI_DATA_WIDTH
- rif_wvalid  in  1  write address hit
- rif_rvalid  in  1  read address hit
- rif_rdata  in  AXI_DATA_WIDTH

Function
REQ-007 FSM states: IDLE, ISSUE, RESP; reset state IDLE.
REQ-008 IDLE: req_ready is asserted combinationally, one-hot, for the granted requester while any req_valid is set; a handshake latches addr, wdata, wstrb, write flag and grant index, then goes to ISSUE.
REQ-009 Arbitration: single request -> grant it; both requesting -> grant the requester not in last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-010 ISSUE, exactly one cycle: rif_addr/rif_wdata/rif_wstrb are driven from the latches; rif_wr_req or rif_rd_req is 1 per the write flag.
- At the end of ISSUE: capture rsp_rdata = rif_rdata for reads, 0 for writes; capture rsp_err = ~rif_wvalid for writes, ~rif_rvalid for reads.
- Then go to RESP and update last_grant.
REQ-011 RESP: rsp_valid[grant] = 1 and is held stable with rsp_rdata/rsp_err until rsp_ready[grant]; then return to IDLE. rsp_ready of the non-granted requester is ignored.
REQ-012 Latency: accept at cycle N, RIF request at N+1, rsp_valid at N+2; with rsp_ready held high, next accept at N+3.
REQ-013 req_ready is 0 in ISSUE and RESP; requests arriving there wait, with no loss and no reordering per requester.
REQ-014 rif_wr_req and rif_rd_req are never both 1; both are 0 outside ISSUE.
REQ-015 rif_addr/wdata/wstrb hold their last latched value outside ISSUE.

Reset
REQ-016 On aresetn low, asynchronously:
- state=IDLE; last_grant=1
- all latches, rif_* outputs, rsp_rdata, rsp_err and rsp_valid = 0
REQ-017 Reset mid-transaction aborts it: no RIF request and no response are issued after reset deasserts.

Configuration
REQ-018 Macro RIF_ARB_STATS_EN. When defined, the block adds outputs grant_cnt0 and grant_cnt1 (16 bits each, reset 0), each incremented on its requester's accept and saturating at 0xFFFF.
REQ-019 When RIF_ARB_STATS_EN is undefined, those ports and counters are absent and all other behaviour is identical.

Structure
REQ-020 Package rif_arb_pkg holds the state enum typedef and the NUM_REQ=2 constant.
REQ-021 Sub-module rr_arbiter2 holds the two-input round-robin grant logic and its last_grant register; the arbiter instantiates it once.

Verification
REQ-022 Single read: req_valid=01, write=0, addr=0x010; rif_rvalid=1, rif_rdata=0xCAFEF00D -> rif_rd_req at N+1; rsp_valid=01 at N+2 with rdata=0xCAFEF00D, err=0.
REQ-023 Write miss: requester 1 writes addr=0x0FC, data=0x12345678, wstrb=0xF; rif_wvalid=0 -> rif_wr_req pulse for one cycle; rsp_valid=10, err=1, rdata=0.
REQ-024 Tie fairness: both req_valid held high for 4 transactions -> grant order 0,1,0,1.
REQ-025 Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=00 throughout, no RIF request issued.
REQ-026 Reset asserted during ISSUE -> all outputs 0 immediately; no rsp_valid after release until a new request.
REQ-027 With RIF_ARB_STATS_EN: 70000 requester-0 accepts -> grant_cnt0=0xFFFF, grant_cnt1=0.
